noc_link_tx: RTL and testbench
==============================

// Module: noc_link_tx
// PURPOSE
//  Output-link transmitter of a NoC router port: upstream end of the on/off flow-controlled link whose receiver is the input circular buffer.
//  Queues flits from the crossbar/local core, sends them one per cycle on the link, and stops while the downstream buffer signals OFF.
//  Tracks wormhole packet framing (head..tail) and flags framing violations.
// PARAMETERS
//  TX_DEPTH  4   internal queue depth in flits; power of two, >=2
//  CNT_W     16  width of statistics counters (used only when NOC_TX_STATS_EN is defined)
// PORTS
//  clk            in   1             clock; single clock domain
//  rst            in   1             asynchronous, active-low reset
//  in_valid       in   1             upstream flit valid
//  in_flit        in   flit_Data     upstream flit
//  in_ready       out  1             queue can accept a flit this cycle
//  link_on_off    in   1             downstream buffer on/off: 1=ON (send allowed), 0=OFF
//  link_valid     out  1             flit on link valid (registered)
//  link_flit      out  flit_Data     flit on link (registered)
//  proto_err      out  1             sticky framing-violation flag
//  flits_sent     out  CNT_W         [NOC_TX_STATS_EN only] flits transmitted
//  stall_cycles   out  CNT_W         [NOC_TX_STATS_EN only] cycles blocked by OFF
// BEHAVIOUR
//  Reset (rst=0, async): queue emptied, link_valid=0, link_flit='0, proto_err=0, on_off_q=0 (OFF), state=IDLE, counters=0; in_ready=1 once rst released.
//  Accept: in_ready = !full (no bypass of a full queue); push when in_valid && in_ready. in_flit ignored when in_valid=0.
//  on_off_q <= link_on_off every cycle (one sync register); only on_off_q gates transmission.
//  Send: at each edge, if queue non-empty && on_off_q=1 -> pop head, link_flit<=it, link_valid<=1; else link_valid<=0, link_flit holds.
//  Latency: flit pushed at edge t (queue empty, on_off_q=1) is on link from edge t+1; throughput 1 flit/cycle while ON.
//  Push and pop same edge: both happen; count unchanged; pop never sees the flit being pushed.
//  OFF latency: link_on_off falling at edge t stops sends from edge t+2; at most 2 more flits leave after OFF; receiver threshold must cover this.
//  OFF mid-packet: transmission pauses at any flit boundary; resumes on ON with next flit; no loss, no duplication, order preserved.
//  Pointers: rd/wr pointers log2(TX_DEPTH)+1 bits, wrap modulo 2*TX_DEPTH; full = MSBs differ & LSBs equal; empty = pointers equal.
//  Framing FSM (advanced on each sent flit, by flit_Type):
//   IDLE: HEAD->ACTIVE; HEADTAIL->IDLE; BODY/TAIL->proto_err=1, stay IDLE.
//   ACTIVE: BODY->ACTIVE; TAIL->IDLE; HEAD/HEADTAIL->proto_err=1, new packet (HEAD->ACTIVE, HEADTAIL->IDLE).
//   Offending flit is still transmitted; proto_err clears only on reset.
//  Reset mid-operation: queued and unsent flits discarded; link_valid drops asynchronously.
// CONFIGURATION
//  NOC_TX_STATS_EN defined: flits_sent increments per link_valid cycle; stall_cycles increments when queue non-empty && on_off_q=0;
//   both saturate at all-ones. Not defined: ports and counters absent, no other change.
// STRUCTURE
//  Package params: flit_Data struct (flit_Type, dest, payload), flit_type enum {HEAD,BODY,TAIL,HEADTAIL}, link-width constants.
//  Sub-module link_tx_fifo (TX_DEPTH x flit_Data queue with push/pop/full/empty); framing FSM, on/off register, stats in top.
// TESTING
//  1 Reset, link_on_off=1, push HEAD,BODY,TAIL back-to-back -> link_valid high 3 consecutive cycles from 1 edge after first push, order kept, proto_err=0.
//  2 link_on_off=0, push 4 flits -> in_ready=0 after 4th, link_valid=0; raise ON -> 4 flits out on consecutive cycles starting 2 edges later.
//  3 Steady ON stream, drop link_on_off for 3 cycles mid-packet -> exactly 2 flits after drop, gap, resume with next flit; no loss/dup.
//  4 Send BODY in IDLE -> proto_err=1 and flit still transmitted; HEAD then HEAD -> proto_err stays 1.
//  5 Queue half full, assert rst=0 mid-stream -> link_valid=0 immediately; after release in_ready=1, no stale flit emitted.
//  6 NOC_TX_STATS_EN: 10 flits, 5 OFF-blocked cycles -> flits_sent=10, stall_cycles=5; force near-max -> counters saturate.

Source files
------------

// File: rtl/noc_link_tx_pkg.sv
// Shared types for the NoC output-link transmitter: flit format, flit kinds
// and the wormhole framing states.
package noc_link_tx_pkg;

  localparam int DEST_W    = 4;
  localparam int PAYLOAD_W = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_type;

  typedef struct packed {
    flit_type               flit_Type;
    logic [DEST_W-1:0]      dest;
    logic [PAYLOAD_W-1:0]   payload;
  } flit_Data;

  localparam int FLIT_W = $bits(flit_Data);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

endpackage

// File: rtl/noc_link_tx_if.sv
// Upstream flit handshake plus the on/off flow-controlled link.
// master = transmitter view, slave = surrounding router/link view.
interface noc_link_tx_if;
  import noc_link_tx_pkg::*;

  logic     in_valid;
  flit_Data in_flit;
  logic     in_ready;
  logic     link_on_off;
  logic     link_valid;
  flit_Data link_flit;

  modport master (
    input  in_valid,
    input  in_flit,
    output in_ready,
    input  link_on_off,
    output link_valid,
    output link_flit
  );

  modport slave (
    output in_valid,
    output in_flit,
    input  in_ready,
    output link_on_off,
    input  link_valid,
    input  link_flit
  );

endinterface

// File: rtl/noc_link_tx_fifo.sv
// Transmit queue: DEPTH flits, pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate counter.
module link_tx_fifo
  import noc_link_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  flit_Data push_data,
  input  logic     pop,
  output flit_Data pop_data,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  flit_Data       mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/noc_link_tx.sv
// NoC output-link transmitter: queues flits, sends one per cycle while the
// downstream buffer is ON, checks wormhole framing. NOC_TX_STATS_EN adds counters.
module noc_link_tx
  import noc_link_tx_pkg::*;
#(
  parameter int TX_DEPTH = 4
`ifdef NOC_TX_STATS_EN
  , parameter int CNT_W  = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  noc_link_tx_if.master     tx,
  output logic              proto_err
`ifdef NOC_TX_STATS_EN
  , output logic [CNT_W-1:0] flits_sent,
  output logic [CNT_W-1:0]   stall_cycles
`endif
);

  logic      on_off_q;
  logic      q_full;
  logic      q_empty;
  logic      do_pop;
  flit_Data  head_flit;
  tx_state_e state;
  tx_state_e next_state;
  logic      err_set;

  assign tx.in_ready = !q_full;
  assign do_pop      = !q_empty && on_off_q;

  link_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx.in_valid && !q_full),
    .push_data (tx.in_flit),
    .pop       (do_pop),
    .pop_data  (head_flit),
    .full      (q_full),
    .empty     (q_empty)
  );

  // Single sync stage: the link can deliver up to two more flits after OFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) on_off_q <= 1'b0;
    else      on_off_q <= tx.link_on_off;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx.link_valid <= 1'b0;
      tx.link_flit  <= '0;
    end else begin
      tx.link_valid <= do_pop;
      if (do_pop) tx.link_flit <= head_flit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      proto_err <= 1'b0;
    end else begin
      state     <= next_state;
      proto_err <= proto_err | err_set;
    end
  end

  // Framing advances on the flit being sent; a bad flit still goes out and
  // an unexpected head simply starts the next packet.
  always_comb begin
    next_state = state;
    err_set    = 1'b0;
    if (do_pop) begin
      case (state)
        IDLE: begin
          case (head_flit.flit_Type)
            HEAD:     next_state = ACTIVE;
            HEADTAIL: next_state = IDLE;
            default:  err_set    = 1'b1;
          endcase
        end
        ACTIVE: begin
          case (head_flit.flit_Type)
            BODY:     next_state = ACTIVE;
            TAIL:     next_state = IDLE;
            HEAD: begin
              err_set    = 1'b1;
              next_state = ACTIVE;
            end
            default: begin
              err_set    = 1'b1;
              next_state = IDLE;
            end
          endcase
        end
        default: next_state = IDLE;
      endcase
    end
  end

`ifdef NOC_TX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flits_sent   <= '0;
      stall_cycles <= '0;
    end else begin
      if (tx.link_valid && (flits_sent != '1))
        flits_sent <= flits_sent + CNT_W'(1);
      if (!q_empty && !on_off_q && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_noc_link_tx.sv
// Directed bench for noc_link_tx with a scoreboard of flits expected on the link.
// Statistics checks are compiled in when NOC_TX_STATS_EN is defined.
module tb_noc_link_tx;
  import noc_link_tx_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  flit_Data sb[$];

  noc_link_tx_if tx_if();

  logic proto_err;
`ifdef NOC_TX_STATS_EN
  logic [3:0] flits_sent;
  logic [3:0] stall_cycles;

  noc_link_tx #(.TX_DEPTH(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx           (tx_if),
    .proto_err    (proto_err),
    .flits_sent   (flits_sent),
    .stall_cycles (stall_cycles)
  );
`else
  noc_link_tx #(.TX_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx        (tx_if),
    .proto_err (proto_err)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic flit_Data mk(input flit_type t, input int n);
    flit_Data f;
    f.flit_Type = t;
    f.dest      = 4'(n);
    f.payload   = 32'hA500_0000 + 32'(n);
    return f;
  endfunction

  function automatic logic [63:0] to_bits(input flit_Data f);
    logic [63:0] r;
    r = '0;
    r[FLIT_W-1:0] = f;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of stimulus at the falling edge; accepted flits go to the scoreboard.
  task automatic applyStimulus(input logic v, input flit_Data f, input logic on);
    @(negedge clk);
    tx_if.in_valid    = v;
    tx_if.in_flit     = f;
    tx_if.link_on_off = on;
    if (v && tx_if.in_ready === 1'b1) sb.push_back(f);
  endtask

  task automatic idle(input int n, input logic on);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, on);
  endtask

  // Every flit seen on the link must be the oldest one still expected.
  always @(negedge clk) begin
    if (rst === 1'b1 && tx_if.link_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL stale_flit observed=%0h expected=none", to_bits(tx_if.link_flit));
      end else begin
        checkOutput("link_flit", to_bits(tx_if.link_flit), to_bits(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    tx_if.in_valid    = 1'b0;
    tx_if.in_flit     = '0;
    tx_if.link_on_off = 1'b1;

    $display("[TB] reset state");
    repeat (2) @(negedge clk);
    checkOutput("rst_link_valid", 64'(tx_if.link_valid), 64'd0);
    checkOutput("rst_link_flit", to_bits(tx_if.link_flit), 64'd0);
    checkOutput("rst_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b1;
    idle(1, 1'b1);
    checkOutput("rst_in_ready", 64'(tx_if.in_ready), 64'd1);
    idle(1, 1'b1);

    $display("[TB] test 1: back-to-back packet");
    applyStimulus(1'b1, mk(HEAD, 1), 1'b1);
    applyStimulus(1'b1, mk(BODY, 2), 1'b1);
    checkOutput("t1_no_bypass", 64'(tx_if.link_valid), 64'd0);
    applyStimulus(1'b1, mk(TAIL, 3), 1'b1);
    checkOutput("t1_valid0", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid1", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid2", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t1_valid_end", 64'(tx_if.link_valid), 64'd0);
    checkOutput("t1_proto_err", 64'(proto_err), 64'd0);

    $display("[TB] test 2: fill while OFF");
    applyStimulus(1'b1, mk(HEAD, 4), 1'b0);
    applyStimulus(1'b1, mk(BODY, 5), 1'b0);
    applyStimulus(1'b1, mk(BODY, 6), 1'b0);
    applyStimulus(1'b1, mk(TAIL, 7), 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("t2_full", 64'(tx_if.in_ready), 64'd0);
    checkOutput("t2_off_valid", 64'(tx_if.link_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t2_on_edge0", 64'(tx_if.link_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t2_on_edge1", 64'(tx_if.link_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      checkOutput($sformatf("t2_burst%0d", i), 64'(tx_if.link_valid), 64'd1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t2_burst_end", 64'(tx_if.link_valid), 64'd0);

    $display("[TB] test 3: OFF mid-packet");
    applyStimulus(1'b1, mk(HEAD, 8), 1'b1);
    applyStimulus(1'b1, mk(BODY, 9), 1'b1);
    applyStimulus(1'b1, mk(BODY, 10), 1'b1);
    checkOutput("t3_stream", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b1, mk(BODY, 11), 1'b0);
    checkOutput("t3_after_off0", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b1, mk(BODY, 12), 1'b0);
    checkOutput("t3_after_off1", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b1, mk(BODY, 13), 1'b0);
    checkOutput("t3_gap0", 64'(tx_if.link_valid), 64'd0);
    applyStimulus(1'b1, mk(BODY, 14), 1'b1);
    checkOutput("t3_gap1", 64'(tx_if.link_valid), 64'd0);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t3_gap2", 64'(tx_if.link_valid), 64'd0);
    applyStimulus(1'b1, mk(TAIL, 15), 1'b1);
    checkOutput("t3_resume", 64'(tx_if.link_valid), 64'd1);
    idle(8, 1'b1);
    checkOutput("t3_no_loss", 64'(sb.size()), 64'd0);
    checkOutput("t3_proto_err", 64'(proto_err), 64'd0);

    $display("[TB] test 4: framing violations");
    applyStimulus(1'b1, mk(BODY, 16), 1'b1);
    idle(3, 1'b1);
    checkOutput("t4_body_in_idle", 64'(proto_err), 64'd1);
    applyStimulus(1'b1, mk(HEAD, 17), 1'b1);
    applyStimulus(1'b1, mk(HEAD, 18), 1'b1);
    applyStimulus(1'b1, mk(TAIL, 19), 1'b1);
    idle(4, 1'b1);
    checkOutput("t4_sticky", 64'(proto_err), 64'd1);
    checkOutput("t4_all_sent", 64'(sb.size()), 64'd0);

    $display("[TB] test 5: reset mid-stream");
    applyStimulus(1'b1, mk(HEAD, 20), 1'b0);
    applyStimulus(1'b1, mk(BODY, 21), 1'b0);
    applyStimulus(1'b1, mk(BODY, 22), 1'b0);
    applyStimulus(1'b1, mk(TAIL, 23), 1'b0);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5_pre_valid", 64'(tx_if.link_valid), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("t5_pre_valid2", 64'(tx_if.link_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("t5_async_valid", 64'(tx_if.link_valid), 64'd0);
    checkOutput("t5_async_flit", to_bits(tx_if.link_flit), 64'd0);
    checkOutput("t5_async_err", 64'(proto_err), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(1, 1'b1);
    checkOutput("t5_in_ready", 64'(tx_if.in_ready), 64'd1);
    idle(5, 1'b1);
    applyStimulus(1'b1, mk(HEAD, 24), 1'b1);
    applyStimulus(1'b1, mk(TAIL, 25), 1'b1);
    idle(4, 1'b1);
    checkOutput("t5_fsm_idle", 64'(proto_err), 64'd0);
    checkOutput("t5_drained", 64'(sb.size()), 64'd0);

`ifdef NOC_TX_STATS_EN
    $display("[TB] test 6: statistics");
    @(negedge clk);
    tx_if.link_on_off = 1'b0;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, mk(HEADTAIL, 30 + i), 1'b0);
    idle(1, 1'b0);
    idle(7, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, mk(HEADTAIL, 40 + i), 1'b1);
    idle(4, 1'b1);
    checkOutput("t6_flits_sent", 64'(flits_sent), 64'd10);
    checkOutput("t6_stall_cycles", 64'(stall_cycles), 64'd5);
    applyStimulus(1'b1, mk(HEADTAIL, 50), 1'b0);
    idle(16, 1'b0);
    idle(3, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, mk(HEADTAIL, 51 + i), 1'b1);
    idle(4, 1'b1);
    checkOutput("t6_sent_sat", 64'(flits_sent), 64'd15);
    checkOutput("t6_stall_sat", 64'(stall_cycles), 64'd15);
    checkOutput("t6_drained", 64'(sb.size()), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
